// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 multi-cycle control unit.
package lc3_ctrl_pkg;

   typedef enum logic [4:0] {
      S_FETCH0   = 5'd0,
      S_FETCH1   = 5'd1,
      S_FETCH2   = 5'd2,
      S_DECODE   = 5'd3,
      S_EXEC_ALU = 5'd4,
      S_BR_CHK   = 5'd5,
      S_JMP      = 5'd6,
      S_LEA      = 5'd7,
      S_ADDR     = 5'd8,
      S_MRD      = 5'd9,
      S_WB       = 5'd10,
      S_SDATA    = 5'd11,
      S_MWR      = 5'd12,
      S_T0       = 5'd13,
      S_T1       = 5'd14,
      S_T2       = 5'd15,
      S_T3       = 5'd16,
      S_HALT     = 5'd17
   } state_t;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_AND  = 2'b10;
   localparam logic [1:0] ALU_NOT  = 2'b11;

   localparam logic [1:0] PCMUX_INC   = 2'b00;
   localparam logic [1:0] PCMUX_BUS   = 2'b01;
   localparam logic [1:0] PCMUX_ADDER = 2'b10;

   localparam logic       ADDR1_PC  = 1'b0;
   localparam logic       ADDR1_SR1 = 1'b1;

   localparam logic [1:0] ADDR2_ZERO  = 2'b00;
   localparam logic [1:0] ADDR2_OFF6  = 2'b01;
   localparam logic [1:0] ADDR2_OFF9  = 2'b10;
   localparam logic [1:0] ADDR2_OFF11 = 2'b11;

   localparam logic       MARMUX_ZEXT  = 1'b0;
   localparam logic       MARMUX_ADDER = 1'b1;

   function automatic logic is_wait(input state_t s);
      return (s == S_FETCH1) || (s == S_MRD) || (s == S_MWR) || (s == S_T2);
   endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// Memory wait timer: counts memReady-low cycles in a wait state, flags timeout.
module lc3_mem_wait #(
   parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic memReady,
   output logic timeout
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Next count: cleared on wait-state entry, saturates at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = 8'd0;
      end else if (!memReady && (cnt_q != MEM_TIMEOUT)) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // This cycle is the MEM_TIMEOUT-th without memReady; a late memReady still wins.
   assign timeout = !memReady && (cnt_q == (MEM_TIMEOUT - 8'd1));

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 multi-cycle control unit: fetch/decode/execute sequencing and datapath controls.
// Define LC3_CTRL_TRAP_EN to execute TRAP; otherwise TRAP halts like an illegal opcode.
module lc3_control_fsm
   import lc3_ctrl_pkg::*;
#(
   parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] IR,
   input  logic        N,
   input  logic        Z,
   input  logic        P,
   input  logic        memReady,
   output logic        ldMAR,
   output logic        ldMDR,
   output logic        ldIR,
   output logic        ldPC,
   output logic        ldREG,
   output logic        ldCC,
   output logic        gatePC,
   output logic        gateMDR,
   output logic        gateALU,
   output logic        gateMARMUX,
   output logic [1:0]  aluControl,
   output logic [1:0]  pcMux,
   output logic        addr1Mux,
   output logic [1:0]  addr2Mux,
   output logic        marMux,
   output logic [2:0]  DR,
   output logic [2:0]  SR1,
   output logic [2:0]  SR2,
   output logic        memEn,
   output logic        memWE,
   output logic        halted,
   output logic        busErr
);

   state_t state_q, state_d;
   logic   ben_q, ben_d;
   logic   busErr_q, busErr_d;
   logic   timeout_s;
   logic   wait_start_s;
   logic   ir_unused_s;
   logic [3:0] opcode_s;

   assign opcode_s     = IR[15:12];
   assign ir_unused_s  = ^IR[5:3];
   assign wait_start_s = is_wait(state_d) && (state_d != state_q);

   lc3_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
      .clk      (clk),
      .reset    (reset),
      .start    (wait_start_s),
      .memReady (memReady),
      .timeout  (timeout_s)
   );

   // State, branch-enable and bus-error registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_FETCH0;
         ben_q    <= 1'b0;
         busErr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ben_q    <= ben_d;
         busErr_q <= busErr_d;
      end
   end

   // Next state and Moore outputs; reset forces every output low immediately.
   always_comb begin
      state_d    = state_q;
      ben_d      = ben_q;
      busErr_d   = busErr_q;
      ldMAR      = 1'b0;
      ldMDR      = 1'b0;
      ldIR       = 1'b0;
      ldPC       = 1'b0;
      ldREG      = 1'b0;
      ldCC       = 1'b0;
      gatePC     = 1'b0;
      gateMDR    = 1'b0;
      gateALU    = 1'b0;
      gateMARMUX = 1'b0;
      aluControl = ALU_PASS;
      pcMux      = PCMUX_INC;
      addr1Mux   = ADDR1_PC;
      addr2Mux   = ADDR2_ZERO;
      marMux     = MARMUX_ZEXT;
      DR         = 3'd0;
      SR1        = 3'd0;
      SR2        = 3'd0;
      memEn      = 1'b0;
      memWE      = 1'b0;
      halted     = 1'b0;
      busErr     = 1'b0;
      if (reset) begin
         state_d = S_FETCH0;
      end else begin
         DR     = IR[11:9];
         SR1    = IR[8:6];
         SR2    = IR[2:0];
         busErr = busErr_q;
         case (state_q)
            S_FETCH0: begin
               ldMAR   = 1'b1;
               gatePC  = 1'b1;
               ldPC    = 1'b1;
               pcMux   = PCMUX_INC;
               state_d = S_FETCH1;
            end
            S_FETCH1: begin
               memEn = 1'b1;
               ldMDR = 1'b1;
               if (memReady) begin
                  state_d = S_FETCH2;
               end else if (timeout_s) begin
                  state_d  = S_HALT;
                  busErr_d = 1'b1;
               end else begin
                  state_d = S_FETCH1;
               end
            end
            S_FETCH2: begin
               gateMDR = 1'b1;
               ldIR    = 1'b1;
               state_d = S_DECODE;
            end
            S_DECODE: begin
               ben_d = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
               case (opcode_s)
                  OP_ADD, OP_AND, OP_NOT:       state_d = S_EXEC_ALU;
                  OP_BR:                        state_d = S_BR_CHK;
                  OP_JMP:                       state_d = S_JMP;
                  OP_LEA:                       state_d = S_LEA;
                  OP_LD, OP_LDR, OP_ST, OP_STR: state_d = S_ADDR;
`ifdef LC3_CTRL_TRAP_EN
                  OP_TRAP:                      state_d = S_T0;
`else
                  OP_TRAP:                      state_d = S_HALT;
`endif
                  default:                      state_d = S_HALT;
               endcase
            end
            S_EXEC_ALU: begin
               gateALU = 1'b1;
               ldREG   = 1'b1;
               ldCC    = 1'b1;
               case (opcode_s)
                  OP_ADD:  aluControl = ALU_ADD;
                  OP_AND:  aluControl = ALU_AND;
                  OP_NOT:  aluControl = ALU_NOT;
                  default: aluControl = ALU_PASS;
               endcase
               state_d = S_FETCH0;
            end
            S_BR_CHK: begin
               if (ben_q) begin
                  ldPC     = 1'b1;
                  pcMux    = PCMUX_ADDER;
                  addr1Mux = ADDR1_PC;
                  addr2Mux = ADDR2_OFF9;
               end else begin
                  ldPC = 1'b0;
               end
               state_d = S_FETCH0;
            end
            S_JMP: begin
               gateALU    = 1'b1;
               aluControl = ALU_PASS;
               ldPC       = 1'b1;
               pcMux      = PCMUX_BUS;
               SR1        = IR[8:6];
               state_d    = S_FETCH0;
            end
            S_LEA: begin
               marMux     = MARMUX_ADDER;
               addr1Mux   = ADDR1_PC;
               addr2Mux   = ADDR2_OFF9;
               gateMARMUX = 1'b1;
               ldREG      = 1'b1;
               ldCC       = 1'b1;
               state_d    = S_FETCH0;
            end
            S_ADDR: begin
               ldMAR      = 1'b1;
               gateMARMUX = 1'b1;
               marMux     = MARMUX_ADDER;
               // PC-relative for LD/ST, base register SR1 for LDR/STR.
               if ((opcode_s == OP_LDR) || (opcode_s == OP_STR)) begin
                  addr1Mux = ADDR1_SR1;
                  addr2Mux = ADDR2_OFF6;
               end else begin
                  addr1Mux = ADDR1_PC;
                  addr2Mux = ADDR2_OFF9;
               end
               if ((opcode_s == OP_ST) || (opcode_s == OP_STR)) begin
                  state_d = S_SDATA;
               end else begin
                  state_d = S_MRD;
               end
            end
            S_MRD: begin
               memEn = 1'b1;
               ldMDR = 1'b1;
               if (memReady) begin
                  state_d = S_WB;
               end else if (timeout_s) begin
                  state_d  = S_HALT;
                  busErr_d = 1'b1;
               end else begin
                  state_d = S_MRD;
               end
            end
            S_WB: begin
               gateMDR = 1'b1;
               ldREG   = 1'b1;
               ldCC    = 1'b1;
               state_d = S_FETCH0;
            end
            S_SDATA: begin
               gateALU    = 1'b1;
               aluControl = ALU_PASS;
               ldMDR      = 1'b1;
               SR1        = IR[11:9];
               state_d    = S_MWR;
            end
            S_MWR: begin
               memEn = 1'b1;
               memWE = 1'b1;
               SR1   = IR[11:9];
               if (memReady) begin
                  state_d = S_FETCH0;
               end else if (timeout_s) begin
                  state_d  = S_HALT;
                  busErr_d = 1'b1;
               end else begin
                  state_d = S_MWR;
               end
            end
`ifdef LC3_CTRL_TRAP_EN
            S_T0: begin
               gatePC  = 1'b1;
               ldREG   = 1'b1;
               DR      = 3'd7;
               state_d = S_T1;
            end
            S_T1: begin
               ldMAR      = 1'b1;
               marMux     = MARMUX_ZEXT;
               gateMARMUX = 1'b1;
               state_d    = S_T2;
            end
            S_T2: begin
               memEn = 1'b1;
               ldMDR = 1'b1;
               if (memReady) begin
                  state_d = S_T3;
               end else if (timeout_s) begin
                  state_d  = S_HALT;
                  busErr_d = 1'b1;
               end else begin
                  state_d = S_T2;
               end
            end
            S_T3: begin
               gateMDR = 1'b1;
               ldPC    = 1'b1;
               pcMux   = PCMUX_BUS;
               state_d = S_FETCH0;
            end
`endif
            S_HALT: begin
               halted  = 1'b1;
               state_d = S_HALT;
            end
            default: begin
               state_d = S_HALT;
            end
         endcase
      end
   end

endmodule
